// File: rtl/sram_bus_slave_pkg.sv
// rtl/sram_bus_slave_pkg.sv - shared types and constants for the SRAM bus responder
package sram_bus_slave_pkg;

   typedef logic        Bit_t;
   typedef logic [31:0] Word_t;

   localparam Word_t ZERO_WORD         = 32'h0000_0000;
   localparam int    SRAM_WAIT_DEFAULT = 2;

   typedef logic [1:0] SramState_t;
   localparam SramState_t SRAM_IDLE   = 2'd0;
   localparam SramState_t SRAM_ACCESS = 2'd1;
   localparam SramState_t SRAM_DONE   = 2'd2;

endpackage

// File: rtl/bus_if.sv
// rtl/bus_if.sv - word request/stall bus between a master stage and a memory responder
interface Bus_if;
   logic        read;
   logic        write;
   logic [31:0] address;
   logic [31:0] data_wr;
   logic [3:0]  mask;
   logic        stall;
   logic [31:0] data_rd;

   modport master (output read, write, address, data_wr, mask, input stall, data_rd);
   modport slave  (input read, write, address, data_wr, mask, output stall, data_rd);
endinterface

// File: rtl/sram_bus_slave.sv
// rtl/sram_bus_slave.sv - Bus_if responder driving an async SRAM with fixed wait states
module sram_bus_slave
   import sram_bus_slave_pkg::*;
#(
   parameter int WAIT_CYCLES = SRAM_WAIT_DEFAULT,
   parameter int ADDR_W      = 20
) (
   input  logic              clk,
   input  logic              rst_n,
   Bus_if.slave              bus,
   output logic [ADDR_W-1:0] sram_addr,
   output logic [31:0]       sram_dq_o,
   input  logic [31:0]       sram_dq_i,
   output logic              sram_dq_oe,
   output logic              sram_ce_n,
   output logic              sram_oe_n,
   output logic              sram_we_n,
   output logic [3:0]        sram_be_n
);

   if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait
      $error("sram_bus_slave: WAIT_CYCLES must be within 1..15");
   end

   localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

   SramState_t        state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [3:0]        be_n_q, be_n_d;
   Word_t             wdata_q, wdata_d;
   Word_t             rdata_q, rdata_d;
   Bit_t              is_wr_q, is_wr_d;

   logic req;
   logic in_access;

   assign req       = bus.read | bus.write;
   assign in_access = (state_q == SRAM_ACCESS);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      be_n_d  = be_n_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      is_wr_d = is_wr_q;
      case (state_q)
         SRAM_IDLE: begin
            if (req) begin
               addr_d  = bus.address[ADDR_W+1:2];
               be_n_d  = ~bus.mask;
               wdata_d = bus.data_wr;
               is_wr_d = bus.write;
               cnt_d   = CNT_INIT;
               state_d = SRAM_ACCESS;
            end
         end
         SRAM_ACCESS: begin
            if (cnt_q == 4'd0) begin
               if (!is_wr_q) rdata_d = sram_dq_i;
               state_d = SRAM_DONE;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         SRAM_DONE: state_d = SRAM_IDLE;
         default:   state_d = SRAM_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= SRAM_IDLE;
         cnt_q   <= 4'd0;
         addr_q  <= '0;
         be_n_q  <= 4'hF;
         wdata_q <= ZERO_WORD;
         rdata_q <= ZERO_WORD;
         is_wr_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         be_n_q  <= be_n_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         is_wr_q <= is_wr_d;
      end
   end

   // Strobes decode straight from the state register so an async reset drops them at once.
   assign sram_ce_n  = ~in_access;
   assign sram_oe_n  = ~(in_access & ~is_wr_q);
   assign sram_we_n  = ~(in_access & is_wr_q);
   assign sram_dq_oe = in_access & is_wr_q;
   assign sram_addr  = addr_q;
   assign sram_be_n  = be_n_q;
   assign sram_dq_o  = wdata_q;

   assign bus.stall   = ((state_q == SRAM_IDLE) & req) | in_access;
   assign bus.data_rd = ((state_q == SRAM_DONE) && !is_wr_q) ? rdata_q : ZERO_WORD;

endmodule

// File: doc/sram_bus_slave.md
Name: sram_bus_slave

Overview:
- Responder end of the Bus_if request/stall protocol.
- Accepts word read/write requests from a Bus_if master (e.g. the instruction fetch stage or the data memory stage) and drives an external asynchronous SRAM with a programmable number of wait states.
- Holds stall high until each access completes, then returns read data for exactly one cycle.

Parameters:
- WAIT_CYCLES, 2, number of cycles the SRAM strobe (oe_n/we_n) is held active per access; legal range 1..15; elaboration error if out of range.
- ADDR_W, 20, SRAM word-address width; byte address bits [ADDR_W+1:2] are used.

Ports:
- clk  input  1  core clock.
- rst_n  input  1  asynchronous, active-low reset.
- bus  Bus_if.slave  interface  master-driven fields are read, write, address[31:0], data_wr[31:0], mask[3:0]; this block drives stall and data_rd[31:0].
- sram_addr  output  ADDR_W  SRAM word address.
- sram_dq_o  output  32  write data to the pad.
- sram_dq_i  input  32  read data from the pad.
- sram_dq_oe  output  1  pad output enable (1 = drive sram_dq_o).
- sram_ce_n  output  1  chip enable, active low.
- sram_oe_n  output  1  output enable, active low.
- sram_we_n  output  1  write enable, active low.
- sram_be_n  output  4  byte enables, active low (~mask).

Behaviour:
- Reset is asynchronous and active-low; one clock (clk).
- Reset values: state IDLE, cnt 0, stall 0, data_rd 0, sram_ce_n/oe_n/we_n 1, sram_be_n 4'hF, sram_dq_oe 0, sram_addr 0, sram_dq_o 0.
- Request = bus.read | bus.write. If both are set, the access is a write.
- stall is combinational: 1 whenever (IDLE and request) or ACCESS; 0 in DONE and in IDLE with no request.
- IDLE, request seen:
  - latch address[ADDR_W+1:2], ~mask, data_wr and op (rd/wr);
  - cnt <= WAIT_CYCLES-1; next state ACCESS.
- ACCESS:
  - ce_n 0; read: oe_n 0, dq_oe 0; write: we_n 0, dq_oe 1.
  - addr, be_n and dq_o come from the latches and stay stable for the whole access.
  - cnt decrements each cycle.
  - When cnt==0: on a read, capture sram_dq_i into the rdata register; next state DONE.
- DONE:
  - all strobes deasserted, dq_oe 0; stall 0.
  - data_rd = rdata register for a read, 0 for a write.
  - Next state IDLE unconditionally; a new request is sampled in IDLE on the following cycle.
- data_rd is 0 in every state other than DONE.
- Latency: for a request first presented in cycle T, stall is high in cycles T..T+WAIT_CYCLES and low in T+WAIT_CYCLES+1, when data_rd is valid. Total occupancy is WAIT_CYCLES+2 cycles.
- Back-to-back: the master may change the request in the cycle after DONE; there is no bubble beyond the DONE→IDLE cycle.
- The master must hold request fields stable while stall=1. Changes after capture are ignored, since the latches are used.
- Request withdrawn mid-ACCESS: the SRAM access still completes; DONE still occurs and the result is discarded by the master.
- mask==0: the access is still performed, with all be_n=1.
- address[1:0] and address[31:ADDR_W+2] are ignored; there is no address-error detection.
- rst_n low mid-access: all strobes deassert immediately (asynchronously), the state returns to IDLE, and the access is lost.

Decomposition:
- Shared package cpu_defs additions:
  - SramState_t enum {SRAM_IDLE, SRAM_ACCESS, SRAM_DONE};
  - `SRAM_WAIT_DEFAULT constant (2).
  - Existing Bit_t, Word_t and `ZERO_WORD are reused.
- No sub-module. The single FSM with its down-counter is small enough to stay flat.

Test Plan:
- Read, WAIT_CYCLES=2: read=1, address=32'h0000_0010, SRAM word 4 = 32'hDEAD_BEEF -> sram_addr=4 and oe_n=0 for 2 cycles; stall=1 for cycles T..T+2; data_rd=32'hDEAD_BEEF with stall=0 at T+3.
- Write with partial mask: write=1, address=32'h0000_0020, data_wr=32'h1234_5678, mask=4'b0011 -> sram_addr=8, be_n=4'b1100, dq_oe=1, we_n=0 for 2 cycles; stall drops at T+3; data_rd=0.
- Back-to-back reads at addresses 0x0, 0x4 and 0x8, request held continuously -> three accesses, each completing 4 cycles apart; each data_rd matches its word; no strobe overlaps DONE.
- read=1 and write=1 together -> a write is performed (we_n active, oe_n stays 1).
- WAIT_CYCLES=1 sweep, then WAIT_CYCLES=15 -> stall high for exactly 2 and 16 cycles respectively.
- Assert rst_n=0 in the 2nd ACCESS cycle of a write -> we_n, ce_n and dq_oe return to 1/1/0 within the same cycle with no clock edge; after release, state is IDLE and stall=0 with no request.
